hwpe_ctrl_job_dispatcher: RTL and testbench
===========================================

# hwpe_ctrl_job_dispatcher

Control-side front end of the HWPE slave. It sits directly upstream of the register file. It decodes peripheral-bus accesses into the per-access flags the register file consumes, which are read, test-and-set, trigger, mandatory and contexted. It also owns the offload lock, the context ring pointers and the engine start/done state machine, and produces the registered response handshake.

## Interface
Parameters:
- N_CONTEXT, 2, number of job contexts, 1..4; LOG_CONTEXT = max(1, $clog2(N_CONTEXT)).
- ID_WIDTH, 16, width of the requester id.
- LOG_REGS, 5, register-index width per context.
- IO_BASE, 16, first contexted (per-job I/O) register index.
- N_GENERIC_REGS, 0, generic registers at index 8..8+N_GENERIC_REGS-1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_req_i  in  1  bus request.
- cfg_gnt_o  out  1  grant, equal to cfg_req_i (combinational, always ready).
- cfg_add_i  in  LOG_REGS+LOG_CONTEXT  word address: [LOG_REGS-1:0] register index r, upper bits context field.
- cfg_wen_i  in  1  1 = read, 0 = write.
- cfg_id_i  in  ID_WIDTH  requester id.
- cfg_r_valid_o  out  1  response valid.
- cfg_r_id_o  out  ID_WIDTH  response id.
- done_i  in  1  engine job-complete pulse.
- start_o  out  1  engine start pulse.
- clear_o  out  1  soft-clear pulse to the datapath and the register file.
- is_read_o, is_testset_o, is_trigger_o, is_mandatory_o, is_contexted_o  out  1 each  access flags.
- is_critical_o, full_context_o, true_done_o  out  1 each  status flags.
- pointer_context_o, running_context_o  out  LOG_CONTEXT each  context pointers.

## Operation
- Access flags are combinational and qualified by cfg_req_i:
  - is_read = cfg_wen_i.
  - is_testset = read of r==1.
  - is_trigger = write of r==0 by the lock owner while the lock is held.
  - is_mandatory = r<8.
  - is_contexted = r>=IO_BASE.
- Lock (is_critical_o = lock held):
  - Testset with lock free and not full: set lock and store owner = cfg_id_i.
  - Testset with lock held, or with full_context_o: no state change.
  - A valid trigger clears the lock.
  - A trigger from a non-owner, or with no lock held, is ignored: no flag, no counter change.
- Context ring:
  - n_queued counts 0..N_CONTEXT; full_context_o = (n_queued==N_CONTEXT).
  - A trigger increments n_queued and advances pointer_context_o modulo N_CONTEXT.
  - A true_done decrements n_queued and advances running_context_o modulo N_CONTEXT.
  - When trigger and true_done occur in the same cycle, n_queued is unchanged and both pointers advance.
- Engine FSM:
  - IDLE: if n_queued>0, go to START.
  - START: start_o=1 for one cycle, then go to RUN.
  - RUN: on done_i go to DONE.
  - DONE: true_done_o=1 for one cycle, then go to START if n_queued-1>0, else IDLE.
  - done_i outside RUN is ignored.
- Soft clear: a write to r==7 pulses clear_o next cycle and resets lock, counters, pointers and FSM to their reset values in that same cycle.

## Timing
- Reset values: all outputs 0, FSM in IDLE, n_queued=0, lock free, owner=0.
- Flags are valid in the request cycle; the register file registers them.
- cfg_r_valid_o and cfg_r_id_o are registered: asserted exactly one cycle after each granted request, reads and writes alike. This aligns with the register file's read data.
- is_critical_o and full_context_o reflect state before the current access, so testset responses see pre-access status.
- Latency:
  - Trigger at cycle T: n_queued updated at T+1; from IDLE, start_o at T+2.
  - done_i at T: true_done_o at T+1; next start_o at T+2 if jobs are queued.
- Back-to-back jobs: start_o to next start_o is at least 3 cycles.
- Reset asserted mid-job: asynchronous return to reset state; the pending response is dropped.

## Test plan
- Reset, then read r==1 with id 3: is_testset_o=1, is_critical_o=0 in that cycle; cfg_r_valid_o=1 and cfg_r_id_o=3 next cycle; is_critical_o=1 after.
- Second testset from id 5 while locked: is_critical_o=1 during access; the later trigger from id 5 gives is_trigger_o=0 and n_queued stays 0.
- Owner 3 triggers: is_trigger_o=1; pointer_context_o 0→1; start_o pulses 2 cycles later; lock freed.
- N_CONTEXT=2: two acquire/trigger pairs with the engine stalled give full_context_o=1; a third testset sees full_context_o=1 and lock stays free.
- done_i in the same cycle as a trigger: n_queued unchanged; running_context_o and pointer_context_o both advance; true_done_o next cycle; start_o the cycle after.
- Write r==7 mid-RUN: clear_o pulses; FSM returns to IDLE; all pointers 0; subsequent done_i ignored.

Source files
------------

// File: rtl/hwpe_ctrl_job_dispatcher.sv
// hwpe_ctrl_job_dispatcher
//
// Control-side front end of the HWPE slave, placed directly upstream of the
// register file. It decodes each peripheral-bus access into the per-access
// flags the register file consumes, owns the offload lock and the context
// ring pointers, runs the engine start/done sequencer and returns the
// registered response handshake.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cfg_req_i / cfg_gnt_o   bus request / grant (always ready)
//   cfg_add_i               word address: [LOG_REGS-1:0] register index,
//                           upper LOG_CONTEXT bits context field
//   cfg_wen_i               1 = read, 0 = write
//   cfg_id_i                requester id
//   cfg_r_valid_o/_id_o     response, one cycle after every granted request
//   done_i                  engine job-complete pulse (honoured only in RUN)
//   start_o                 engine start pulse
//   clear_o                 soft-clear pulse to datapath and register file
//   is_*_o                  per-access flags, valid in the request cycle
//   is_critical_o           offload lock held
//   full_context_o          all job contexts queued
//   true_done_o             one-cycle pulse when a job retires
//   pointer_context_o       context the next offload is written to
//   running_context_o       context the engine is executing
//
// Engine sequencer states
//   state | meaning
//   IDLE  | no job running, waiting for a queued context
//   START | start_o pulse for the job in running_context_o
//   RUN   | engine busy, waiting for done_i
//   DONE  | true_done_o pulse, job retired, pick the next one or idle

module hwpe_ctrl_job_dispatcher #(
  parameter int unsigned N_CONTEXT      = 2,
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned LOG_REGS       = 5,
  parameter int unsigned IO_BASE        = 16,
  parameter int unsigned N_GENERIC_REGS = 0,
  localparam int unsigned LOG_CONTEXT   = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_req_i,
  output logic                            cfg_gnt_o,
  input  logic [LOG_REGS+LOG_CONTEXT-1:0] cfg_add_i,
  input  logic                            cfg_wen_i,
  input  logic [ID_WIDTH-1:0]             cfg_id_i,
  output logic                            cfg_r_valid_o,
  output logic [ID_WIDTH-1:0]             cfg_r_id_o,
  input  logic                            done_i,
  output logic                            start_o,
  output logic                            clear_o,
  output logic                            is_read_o,
  output logic                            is_testset_o,
  output logic                            is_trigger_o,
  output logic                            is_mandatory_o,
  output logic                            is_contexted_o,
  output logic                            is_critical_o,
  output logic                            full_context_o,
  output logic                            true_done_o,
  output logic [LOG_CONTEXT-1:0]          pointer_context_o,
  output logic [LOG_CONTEXT-1:0]          running_context_o
);

  localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);

  if (N_CONTEXT < 1 || N_CONTEXT > 4) begin : g_bad_n_context
    $error("N_CONTEXT must be in 1..4");
  end
  if (IO_BASE < 8 + N_GENERIC_REGS) begin : g_bad_reg_map
    $error("generic registers overlap the contexted I/O registers");
  end

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     lock_q;
  logic [ID_WIDTH-1:0]      owner_q;
  logic [CNT_W-1:0]         n_queued_q;
  logic [LOG_CONTEXT-1:0]   ptr_q, run_ptr_q;
  logic                     clear_q;
  logic                     r_valid_q;
  logic [ID_WIDTH-1:0]      r_id_q;

  logic [31:0]              r_idx;
  logic                     wr_access;
  logic                     testset;
  logic                     trigger;
  logic                     clear_req;
  logic                     full;
  logic                     retire;
  logic                     unused_ctx_field;

  function automatic logic [LOG_CONTEXT-1:0] ring_next(input logic [LOG_CONTEXT-1:0] p);
    if (p == LOG_CONTEXT'(N_CONTEXT - 1)) return '0;
    else return p + LOG_CONTEXT'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  // The context field only matters to the register file.
  assign unused_ctx_field = ^cfg_add_i[LOG_REGS +: LOG_CONTEXT];

  assign r_idx     = 32'(cfg_add_i[LOG_REGS-1:0]);
  assign wr_access = cfg_req_i & ~cfg_wen_i;
  assign testset   = cfg_req_i & cfg_wen_i & (r_idx == 32'd1);
  // Only the current lock owner can commit a job; anything else is a plain write.
  assign trigger   = wr_access & (r_idx == 32'd0) & lock_q & (owner_q == cfg_id_i);
  assign clear_req = wr_access & (r_idx == 32'd7);
  assign full      = (n_queued_q == CNT_W'(N_CONTEXT));

  assign cfg_gnt_o      = cfg_req_i;
  assign is_read_o      = cfg_req_i & cfg_wen_i;
  assign is_testset_o   = testset;
  assign is_trigger_o   = trigger;
  assign is_mandatory_o = cfg_req_i & (r_idx < 32'd8);
  assign is_contexted_o = cfg_req_i & (r_idx >= IO_BASE);

  // Status reflects the state before the current access so a testset read
  // returns the pre-acquire view.
  assign is_critical_o     = lock_q;
  assign full_context_o    = full;
  assign pointer_context_o = ptr_q;
  assign running_context_o = run_ptr_q;
  assign clear_o           = clear_q;
  assign cfg_r_valid_o     = r_valid_q;
  assign cfg_r_id_o        = r_id_q;

  // ---------------------------------------------------------------------------
  // Offload lock
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (clear_req) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (testset && !lock_q && !full) begin
      lock_q  <= 1'b1;
      owner_q <= cfg_id_i;
    end else if (trigger) begin
      lock_q  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Context ring
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_queued_q <= '0;
      ptr_q      <= '0;
      run_ptr_q  <= '0;
    end else if (clear_req) begin
      n_queued_q <= '0;
      ptr_q      <= '0;
      run_ptr_q  <= '0;
    end else begin
      case ({trigger, retire})
        2'b10:   n_queued_q <= n_queued_q + CNT_W'(1);
        2'b01:   n_queued_q <= n_queued_q - CNT_W'(1);
        default: n_queued_q <= n_queued_q;
      endcase
      if (trigger) ptr_q     <= ring_next(ptr_q);
      if (retire)  run_ptr_q <= ring_next(run_ptr_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Engine sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (n_queued_q != '0) state_d = START;
      START:   state_d = RUN;
      RUN:     if (done_i) state_d = DONE;
      // The retiring job is still counted here, so more than one means another waits.
      DONE:    state_d = (n_queued_q > CNT_W'(1)) ? START : IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_req) state_d = IDLE;
  end

  always_comb begin
    start_o = 1'b0;
    retire  = 1'b0;
    case (state_q)
      START:   start_o = 1'b1;
      DONE:    retire  = 1'b1;
      default: ;
    endcase
  end

  assign true_done_o = retire;

  // ---------------------------------------------------------------------------
  // Soft clear and response handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clear_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
    end else begin
      clear_q   <= clear_req;
      r_valid_q <= cfg_req_i;
      if (cfg_req_i) r_id_q <= cfg_id_i;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// Directed bench for hwpe_ctrl_job_dispatcher with default parameters
// (N_CONTEXT=2, ID_WIDTH=16, LOG_REGS=5, IO_BASE=16, 6-bit address).
// Inputs change 1 ns after the rising edge; outputs are sampled a few ns later.

module tb_hwpe_ctrl_job_dispatcher;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [5:0]  add;
  logic        wen;
  logic [15:0] id;
  logic        r_valid;
  logic [15:0] r_id;
  logic        done;
  logic        start;
  logic        clear;
  logic        f_read, f_testset, f_trigger, f_mandatory, f_contexted;
  logic        crit, full, tdone;
  logic        ptr, run;

  int n_assert = 0;
  int n_fail   = 0;

  hwpe_ctrl_job_dispatcher dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cfg_req_i         (req),
    .cfg_gnt_o         (gnt),
    .cfg_add_i         (add),
    .cfg_wen_i         (wen),
    .cfg_id_i          (id),
    .cfg_r_valid_o     (r_valid),
    .cfg_r_id_o        (r_id),
    .done_i            (done),
    .start_o           (start),
    .clear_o           (clear),
    .is_read_o         (f_read),
    .is_testset_o      (f_testset),
    .is_trigger_o      (f_trigger),
    .is_mandatory_o    (f_mandatory),
    .is_contexted_o    (f_contexted),
    .is_critical_o     (crit),
    .full_context_o    (full),
    .true_done_o       (tdone),
    .pointer_context_o (ptr),
    .running_context_o (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic we, input logic [5:0] a, input logic [15:0] i);
    req = rq;
    wen = we;
    add = a;
    id  = i;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'd0, 16'd0);
  endtask

  initial begin
    rst = 1'b1; done = 1'b0;
    idle();
    #2;
    // reset state
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_start", start, 0);
    chk("rst_clear", clear, 0);
    chk("rst_crit", crit, 0);
    chk("rst_full", full, 0);
    chk("rst_tdone", tdone, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_run", run, 0);
    tick(); tick();
    rst = 1'b0;

    // flags are gated by the request
    drive(1'b0, 1'b1, 6'd1, 16'd3); #1;
    chk("noreq_gnt", gnt, 0);
    chk("noreq_read", f_read, 0);
    chk("noreq_testset", f_testset, 0);
    chk("noreq_mandatory", f_mandatory, 0);
    // r=15: neither mandatory nor contexted
    drive(1'b1, 1'b1, 6'd15, 16'd8); #1;
    chk("r15_contexted", f_contexted, 0);
    chk("r15_mandatory", f_mandatory, 0);
    // context 1, r=16: contexted boundary
    drive(1'b1, 1'b1, 6'h30, 16'd8); #1;
    chk("r16_gnt", gnt, 1);
    chk("r16_contexted", f_contexted, 1);
    chk("r16_mandatory", f_mandatory, 0);
    chk("r16_testset", f_testset, 0);
    tick(); idle(); #1;
    chk("r16_r_valid", r_valid, 1);
    chk("r16_r_id", r_id, 16'd8);

    // acquire lock with id 3
    tick(); drive(1'b1, 1'b1, 6'd1, 16'd3); #1;
    chk("ts3_testset", f_testset, 1);
    chk("ts3_read", f_read, 1);
    chk("ts3_mandatory", f_mandatory, 1);
    chk("ts3_crit_pre", crit, 0);
    tick(); idle(); #1;
    chk("ts3_r_valid", r_valid, 1);
    chk("ts3_r_id", r_id, 16'd3);
    chk("ts3_crit_post", crit, 1);
    tick(); #1;
    chk("ts3_r_valid_drop", r_valid, 0);

    // id 5 cannot steal or trigger
    drive(1'b1, 1'b1, 6'd1, 16'd5); #1;
    chk("ts5_testset", f_testset, 1);
    chk("ts5_crit", crit, 1);
    tick(); drive(1'b1, 1'b0, 6'd0, 16'd5); #1;
    chk("trg5_trigger", f_trigger, 0);
    tick(); idle(); #1;
    chk("trg5_ptr", ptr, 0);
    chk("trg5_crit", crit, 1);
    tick(); #1;
    chk("trg5_start_a", start, 0);
    tick(); #1;
    chk("trg5_start_b", start, 0);

    // owner 3 triggers: T
    drive(1'b1, 1'b0, 6'd0, 16'd3); #1;
    chk("trg3_trigger", f_trigger, 1);
    tick(); idle(); #1;                 // T+1
    chk("trg3_ptr", ptr, 1);
    chk("trg3_crit", crit, 0);
    chk("trg3_start_early", start, 0);
    tick(); #1;                         // T+2
    chk("trg3_start", start, 1);
    tick(); #1;                         // T+3, RUN
    chk("trg3_start_end", start, 0);

    // second job fills the ring while the engine is stalled
    drive(1'b1, 1'b1, 6'd1, 16'd7); #1;
    chk("ts7_full", full, 0);
    tick(); drive(1'b1, 1'b0, 6'd0, 16'd7); #1;
    chk("trg7_crit", crit, 1);
    chk("trg7_trigger", f_trigger, 1);
    tick(); idle(); #1;
    chk("trg7_ptr_wrap", ptr, 0);
    chk("trg7_full", full, 1);
    drive(1'b1, 1'b1, 6'd1, 16'd9); #1;
    chk("ts9_testset", f_testset, 1);
    chk("ts9_full", full, 1);
    tick(); drive(1'b1, 1'b0, 6'd0, 16'd9); #1;
    chk("ts9_crit_free", crit, 0);
    chk("trg9_trigger", f_trigger, 0);
    tick(); idle(); #1;
    chk("trg9_full", full, 1);
    chk("trg9_ptr", ptr, 0);
    chk("stall_tdone", tdone, 0);

    // retire the first job
    done = 1'b1;
    tick(); done = 1'b0; #1;
    chk("d1_tdone", tdone, 1);
    chk("d1_run_pre", run, 0);
    tick(); #1;
    chk("d1_start", start, 1);
    chk("d1_run", run, 1);
    chk("d1_full", full, 0);
    drive(1'b1, 1'b1, 6'd1, 16'd4); #1;
    tick(); idle(); #1;                 // RUN
    chk("ts4_crit", crit, 1);
    chk("ts4_start_end", start, 0);

    // trigger coincident with done_i: U
    drive(1'b1, 1'b0, 6'd0, 16'd4); done = 1'b1; #1;
    chk("u_trigger", f_trigger, 1);
    tick(); idle(); done = 1'b0; #1;    // U+1
    chk("u1_tdone", tdone, 1);
    chk("u1_ptr", ptr, 1);
    chk("u1_run", run, 1);
    chk("u1_full", full, 1);
    chk("u1_crit", crit, 0);
    tick(); #1;                         // U+2
    chk("u2_start", start, 1);
    chk("u2_run", run, 0);
    chk("u2_full", full, 0);
    tick(); drive(1'b1, 1'b1, 6'd1, 16'd6); #1;   // U+3, RUN
    chk("ts6_testset", f_testset, 1);
    chk("ts6_crit_pre", crit, 0);
    tick(); idle(); done = 1'b1; #1;    // U+4
    chk("ts6_crit", crit, 1);
    tick(); done = 1'b0; drive(1'b1, 1'b0, 6'd0, 16'd6); #1;   // U+5, DONE
    chk("u5_tdone", tdone, 1);
    chk("u5_trigger", f_trigger, 1);
    tick(); idle(); #1;                 // U+6: count unchanged at 1, DONE->IDLE
    chk("u6_ptr", ptr, 0);
    chk("u6_run", run, 1);
    chk("u6_full", full, 0);
    chk("u6_start", start, 0);
    chk("u6_tdone", tdone, 0);
    tick(); #1;                         // U+7
    chk("u7_start", start, 1);
    tick(); #1;                         // U+8, RUN
    chk("u8_start", start, 0);

    // soft clear mid-RUN
    drive(1'b1, 1'b0, 6'd7, 16'd2); #1;
    chk("clr_mandatory", f_mandatory, 1);
    chk("clr_trigger", f_trigger, 0);
    chk("clr_pulse_pre", clear, 0);
    tick(); idle(); #1;
    chk("clr_pulse", clear, 1);
    chk("clr_run", run, 0);
    chk("clr_ptr", ptr, 0);
    chk("clr_r_valid", r_valid, 1);
    chk("clr_r_id", r_id, 16'd2);
    done = 1'b1;
    tick(); done = 1'b0; #1;
    chk("clr_pulse_end", clear, 0);
    chk("clr_done_ignored", tdone, 0);
    tick(); #1;
    chk("clr_no_start_a", start, 0);
    chk("clr_no_tdone", tdone, 0);
    tick(); #1;
    chk("clr_no_start_b", start, 0);

    // asynchronous reset with a response pending
    drive(1'b1, 1'b1, 6'd1, 16'd2); #1;
    chk("ts2_crit_pre", crit, 0);
    tick(); drive(1'b1, 1'b1, 6'd1, 16'd12); #1;
    chk("ts2_crit", crit, 1);
    chk("ts2_r_valid", r_valid, 1);
    #2 rst = 1'b1; #1;
    chk("arst_crit", crit, 0);
    chk("arst_r_valid", r_valid, 0);
    tick(); #1;
    chk("arst_dropped_valid", r_valid, 0);
    chk("arst_dropped_id", r_id, 0);
    idle();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
